// File: rtl/snake_pkg.sv
// snake_pkg: opcodes, FSM states, grid/score limits and colours shared by spi_cmd_ctrl and vga_top
package snake_pkg;
  localparam int CELLS = 768;
  localparam int SCORE_MAX = 999;
  typedef enum logic [7:0] {
    OP_NOP        = 8'h00,
    OP_WRITE_CELL = 8'h01,
    OP_SET_SCORE  = 8'h02,
    OP_ADD_SCORE  = 8'h03,
    OP_SET_STATE  = 8'h04,
    OP_FILL       = 8'h05
  } opcode_t;
  typedef enum logic [1:0] {IDLE, EXEC, FILL} fsm_t;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer; resets to 1 so a low input after reset never looks like a rising edge
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) {s2_q, s1_q} <= 2'b11;
    else {s2_q, s1_q} <= {s1_q, d};
  end
  assign q = s2_q;
endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SPI frame decoder driving tile writes, score and game state.
// Define CLEAR_FILL_EN to build the screen-fill command with its 1-entry pending frame buffer.
module spi_cmd_ctrl #(
  parameter int CELLS = snake_pkg::CELLS,
  parameter int SCORE_MAX = snake_pkg::SCORE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [7:0]  command,
  input  logic [7:0]  databyte1,
  input  logic [7:0]  databyte2,
  output logic        we,
  output logic [9:0]  waddr,
  output logic [2:0]  wdata,
  output logic [9:0]  score,
  output logic [15:0] state,
  output logic        busy,
  output logic        err
);
  import snake_pkg::*;
  fsm_t fsm_q, fsm_d;
  logic cs_s, cs_prev_q, frame, go, drop, fill_start;
  logic [23:0] src;
  logic we_q, we_d, busy_q, busy_d, err_q, err_d;
  logic [9:0] waddr_q, waddr_d, score_q, score_d;
  logic [2:0] wdata_q, wdata_d;
  logic [15:0] state_q, state_d;
  logic [10:0] sum;
  function automatic logic [9:0] sat(input logic [10:0] v);
    return (v > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : v[9:0];
  endfunction
  sync2 u_sync (.clk(clk), .reset(reset), .d(cs), .q(cs_s));
  assign frame = cs_s & ~cs_prev_q;
`ifdef CLEAR_FILL_EN
  logic pend_q, pend_d, use_pend, to_pend, fill_q, fill_d;
  logic [23:0] pbuf_q, pbuf_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] col_q, col_d;
  // a held frame takes priority; a new frame then refills the buffer it frees
  assign use_pend = fsm_q == IDLE && pend_q;
  assign go = use_pend || (frame && fsm_q == IDLE);
  assign src = use_pend ? pbuf_q : {command, databyte1, databyte2};
  assign drop = frame && pend_q && !use_pend;
  assign to_pend = frame && !drop && !(fsm_q == IDLE && !pend_q);
  assign fill_start = fill_q;
  always_comb begin
    pend_d = to_pend | (pend_q & ~use_pend);
    pbuf_d = to_pend ? {command, databyte1, databyte2} : pbuf_q;
    cnt_d = fsm_q == FILL ? cnt_q + 10'd1 : 10'd0;
    fill_d = go ? src[23:16] == OP_FILL : fill_q;
    col_d = go ? src[10:8] : col_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      pbuf_q <= '0;
      cnt_q <= '0;
      fill_q <= 1'b0;
      col_q <= '0;
    end else begin
      pend_q <= pend_d;
      pbuf_q <= pbuf_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      col_q <= col_d;
    end
  end
`else
  assign go = frame && fsm_q == IDLE;
  assign src = {command, databyte1, databyte2};
  assign drop = 1'b0;
  assign fill_start = 1'b0;
`endif
  always_comb begin
    fsm_d = fsm_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    score_d = score_q;
    state_d = state_q;
    busy_d = 1'b0;
    err_d = err_q | drop;
    sum = {1'b0, score_q} + {3'b000, src[7:0]};
    if (go) begin
      fsm_d = EXEC;
      case (src[23:16])
        OP_WRITE_CELL: begin
          if (int'(src[9:0]) < CELLS) begin
            we_d = 1'b1;
            waddr_d = src[9:0];
            wdata_d = src[15:13];
          end else err_d = 1'b1;
        end
        OP_SET_SCORE: score_d = sat({1'b0, src[9:0]});
        OP_ADD_SCORE: score_d = sat(sum);
        OP_SET_STATE: state_d = src[15:0];
`ifdef CLEAR_FILL_EN
        OP_FILL: ;
`endif
        default: err_d = 1'b1;
      endcase
    end else if (fsm_q == EXEC) fsm_d = fill_start ? FILL : IDLE;
`ifdef CLEAR_FILL_EN
    else if (fsm_q == FILL) begin
      we_d = 1'b1;
      busy_d = 1'b1;
      waddr_d = cnt_q;
      wdata_d = col_q;
      fsm_d = cnt_q == 10'(CELLS - 1) ? IDLE : FILL;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= IDLE;
      cs_prev_q <= 1'b1;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      score_q <= '0;
      state_q <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cs_prev_q <= cs_s;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      score_q <= score_d;
      state_q <= state_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign score = score_q;
  assign state = state_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule
